// File: rtl/readout_stream_fifo.sv
// Result-word FIFO that streams a snapshot of its contents over a valid/ready port on command.
// Optional: define READOUT_XOR_EN to append an XOR checksum word after each snapshot.
module readout_stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             readout_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

`ifdef READOUT_XOR_EN
    typedef enum logic [1:0] {StIdle, StStream, StCheck} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStream} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             overflow_q, overflow_d;
`ifdef READOUT_XOR_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;
`endif
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle);
    assign pop      = (state_q == StStream) && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign push     = wr_en && (!full || pop);

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        out_valid   = 1'b0;
        out_data    = '0;
`ifdef READOUT_XOR_EN
        checksum_d  = checksum_q;
`endif
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (wr_en && !push) overflow_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (readout_start && !empty) begin
                    state_d     = StStream;
                    remaining_d = count_q;
`ifdef READOUT_XOR_EN
                    checksum_d  = '0;
`endif
                end
            end
            StStream: begin
                out_valid = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                if (pop) begin
                    rd_ptr_d    = ptr_inc(rd_ptr_q);
                    remaining_d = remaining_q - CNT_W'(1);
`ifdef READOUT_XOR_EN
                    checksum_d  = checksum_q ^ mem_q[rd_ptr_q];
                    if (remaining_q == CNT_W'(1)) state_d = StCheck;
`else
                    if (remaining_q == CNT_W'(1)) state_d = StIdle;
`endif
                end
            end
`ifdef READOUT_XOR_EN
            StCheck: begin
                out_valid = 1'b1;
                out_data  = checksum_q;
                if (out_ready) begin
                    state_d    = StIdle;
                    checksum_d = '0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
`ifdef READOUT_XOR_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
`ifdef READOUT_XOR_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // Storage needs no reset: empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
